// File: rtl/ula_result_fifo_if.sv
// Handshake bundle between the ALU (producer), the result FIFO and its consumer.
interface ula_result_fifo_if #(
    parameter int DEPTH = 4,
    parameter int RES_W = 32
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [RES_W-1:0] in_result;
    logic             in_carry;
    logic [4:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_result;
    logic             out_carry;
    logic [4:0]       out_op;
    logic [7:0]       out_seq;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             empty;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic             clr_overflow;

    modport master (
        output in_valid, in_result, in_carry, in_op, out_ready, clr_overflow,
        input  out_valid, out_result, out_carry, out_op, out_seq,
        input  level, full, empty, overflow, drop_cnt
    );

    modport slave (
        input  in_valid, in_result, in_carry, in_op, out_ready, clr_overflow,
        output out_valid, out_result, out_carry, out_op, out_seq,
        output level, full, empty, overflow, drop_cnt
    );
endinterface

// File: rtl/ula_result_fifo.sv
// Circular result buffer behind the ALU: tags each result with a sequence number
// and records results dropped while full so the consumer can detect gaps.
module ula_result_fifo #(
    parameter int DEPTH = 4,
    parameter int RES_W = 32
) (
    input logic               clk,
    input logic               rst,
    ula_result_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             carry;
        logic [4:0]       op;
        logic [7:0]       seq;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [LVL_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         seq_q, seq_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         drop_q, drop_d;
    logic               full, empty, push, pop, drop;
    entry_t             head, wr_ent;

    assign full  = (cnt_q == LVL_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign pop   = !empty && bus.out_ready;
    // A pop frees the head slot this edge, so a full buffer can still accept.
    assign push  = bus.in_valid && (!full || pop);
    assign drop  = bus.in_valid && full && !pop;

    assign wr_ent = '{result: bus.in_result, carry: bus.in_carry,
                      op: bus.in_op, seq: seq_q};

    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        seq_d  = seq_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (pop)  rd_d = rd_q + PTR_W'(1);
        if (push) wr_d = wr_q + PTR_W'(1);
        if (push && !pop)      cnt_d = cnt_q + LVL_W'(1);
        else if (pop && !push) cnt_d = cnt_q - LVL_W'(1);
        if (bus.in_valid) seq_d = seq_q + 8'd1;
        // A drop coinciding with a clear restarts the count at this drop.
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = bus.clr_overflow ? 8'd1 :
                     (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end else if (bus.clr_overflow) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            seq_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            seq_q  <= seq_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
            if (push) mem_q[wr_q] <= wr_ent;
        end
    end

    assign head           = mem_q[rd_q];
    assign bus.out_valid  = !empty;
    assign bus.out_result = empty ? '0 : head.result;
    assign bus.out_carry  = empty ? 1'b0 : head.carry;
    assign bus.out_op     = empty ? 5'd0 : head.op;
    assign bus.out_seq    = empty ? 8'd0 : head.seq;
    assign bus.level      = cnt_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.overflow   = ovf_q;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_ula_result_fifo.sv
// Directed bench for ula_result_fifo (DEPTH=4, RES_W=32) with hand-computed expectations.
module tb_ula_result_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ula_result_fifo_if #(.DEPTH(4), .RES_W(32)) ifc ();
    ula_result_fifo #(.DEPTH(4), .RES_W(32)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        ifc.in_valid = 0; ifc.in_result = '0; ifc.in_carry = 0; ifc.in_op = '0;
        ifc.out_ready = 0; ifc.clr_overflow = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        cyc(2);
        rst = 1;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        ifc.in_valid = 1; ifc.in_result = 32'hDEAD_BEEF; ifc.in_op = 5'd7; ifc.in_carry = 1;
        cyc(3);
        n_chk++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", ifc.out_valid); end
        n_chk++; if (ifc.out_result !== 32'd0) begin n_fail++; $display("FAIL rst_out_result got %h exp 0", ifc.out_result); end
        n_chk++; if (ifc.out_seq !== 8'd0 || ifc.out_op !== 5'd0 || ifc.out_carry !== 1'b0) begin n_fail++; $display("FAIL rst_out_fields seq %h op %h carry %b exp 0", ifc.out_seq, ifc.out_op, ifc.out_carry); end
        n_chk++; if (ifc.level !== 3'd0 || ifc.empty !== 1'b1 || ifc.full !== 1'b0) begin n_fail++; $display("FAIL rst_level level %0d empty %b full %b exp 0/1/0", ifc.level, ifc.empty, ifc.full); end
        n_chk++; if (ifc.overflow !== 1'b0 || ifc.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_overflow ovf %b drop %0d exp 0/0", ifc.overflow, ifc.drop_cnt); end
        rst = 1;
        ifc.in_valid = 1; ifc.in_result = 32'h0000_00FF; ifc.in_op = 5'd1; ifc.in_carry = 0;
        cyc();
        idle();
        n_chk++; if (ifc.out_valid !== 1'b1 || ifc.out_result !== 32'h0000_00FF) begin n_fail++; $display("FAIL first_push valid %b result %h exp 1/000000ff", ifc.out_valid, ifc.out_result); end
        n_chk++; if (ifc.out_op !== 5'd1 || ifc.out_seq !== 8'd0 || ifc.level !== 3'd1) begin n_fail++; $display("FAIL first_push_tag op %0d seq %0d level %0d exp 1/0/1", ifc.out_op, ifc.out_seq, ifc.level); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ifc.in_valid = 1; ifc.in_result = 32'(i + 1); ifc.in_carry = i[0]; ifc.in_op = 5'(i + 2);
            cyc();
        end
        idle();
        n_chk++; if (ifc.full !== 1'b1 || ifc.level !== 3'd4 || ifc.empty !== 1'b0) begin n_fail++; $display("FAIL fill_full full %b level %0d empty %b exp 1/4/0", ifc.full, ifc.level, ifc.empty); end
        cyc(2);
        n_chk++; if (ifc.out_result !== 32'd1 || ifc.out_seq !== 8'd0) begin n_fail++; $display("FAIL fill_hold result %h seq %0d exp 1/0", ifc.out_result, ifc.out_seq); end
        ifc.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (ifc.out_result !== 32'(i + 1) || ifc.out_seq !== 8'(i) || ifc.out_carry !== i[0] || ifc.out_op !== 5'(i + 2)) begin
                n_fail++;
                $display("FAIL drain_%0d result %h seq %0d carry %b op %0d exp %h/%0d/%b/%0d", i, ifc.out_result, ifc.out_seq, ifc.out_carry, ifc.out_op, i + 1, i, i[0], i + 2);
            end
            cyc();
        end
        idle();
        n_chk++; if (ifc.empty !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.level !== 3'd0) begin n_fail++; $display("FAIL drain_empty empty %b valid %b level %0d exp 1/0/0", ifc.empty, ifc.out_valid, ifc.level); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ifc.in_valid = 1; ifc.in_result = 32'(i + 1);
            cyc();
        end
        idle();
        n_chk++; if (ifc.overflow !== 1'b1 || ifc.drop_cnt !== 8'd2 || ifc.level !== 3'd4) begin n_fail++; $display("FAIL ovf_drop ovf %b drop %0d level %0d exp 1/2/4", ifc.overflow, ifc.drop_cnt, ifc.level); end
        ifc.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (ifc.out_result !== 32'(i + 1)) begin n_fail++; $display("FAIL ovf_drain_%0d result %h exp %h", i, ifc.out_result, i + 1); end
            cyc();
        end
        ifc.out_ready = 0;
        ifc.in_valid = 1; ifc.in_result = 32'h77;
        cyc();
        idle();
        n_chk++; if (ifc.out_seq !== 8'd6 || ifc.out_result !== 32'h77) begin n_fail++; $display("FAIL ovf_gap seq %0d result %h exp 6/77", ifc.out_seq, ifc.out_result); end
        ifc.clr_overflow = 1;
        cyc();
        idle();
        n_chk++; if (ifc.overflow !== 1'b0 || ifc.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_clear ovf %b drop %0d exp 0/0", ifc.overflow, ifc.drop_cnt); end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ifc.in_valid = 1; ifc.in_result = 32'(100 + i);
            cyc();
        end
        ifc.out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            ifc.in_valid = 1; ifc.in_result = 32'(104 + i);
            n_chk++; if (ifc.out_result !== 32'(100 + i) || ifc.out_seq !== 8'(i)) begin n_fail++; $display("FAIL ppf_head_%0d result %0d seq %0d exp %0d/%0d", i, ifc.out_result, ifc.out_seq, 100 + i, i); end
            cyc();
            n_chk++; if (ifc.level !== 3'd4) begin n_fail++; $display("FAIL ppf_level_%0d level %0d exp 4", i, ifc.level); end
        end
        idle();
        n_chk++; if (ifc.overflow !== 1'b0 || ifc.drop_cnt !== 8'd0 || ifc.out_result !== 32'd110) begin n_fail++; $display("FAIL ppf_end ovf %b drop %0d head %0d exp 0/0/110", ifc.overflow, ifc.drop_cnt, ifc.out_result); end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            ifc.in_valid = 1; ifc.in_result = 32'(i);
            cyc();
        end
        idle();
        n_chk++; if (ifc.drop_cnt !== 8'd255 || ifc.overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_sat drop %0d ovf %b exp 255/1", ifc.drop_cnt, ifc.overflow); end
        ifc.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (ifc.out_result !== 32'(i) || ifc.out_seq !== 8'(i)) begin n_fail++; $display("FAIL wrap_drain_%0d result %0d seq %0d exp %0d", i, ifc.out_result, ifc.out_seq, i); end
            cyc();
        end
        ifc.out_ready = 0;
        ifc.in_valid = 1; ifc.in_result = 32'h1234;
        cyc();
        idle();
        n_chk++; if (ifc.out_seq !== 8'd44 || ifc.out_result !== 32'h1234) begin n_fail++; $display("FAIL wrap_seq seq %0d result %h exp 44/1234", ifc.out_seq, ifc.out_result); end
        n_chk++; if (ifc.drop_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_hold drop %0d exp 255", ifc.drop_cnt); end
    endtask

    task automatic test_clr_vs_drop();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ifc.in_valid = 1; ifc.in_result = 32'(i);
            cyc();
        end
        ifc.clr_overflow = 1;
        cyc();
        idle();
        n_chk++; if (ifc.overflow !== 1'b1 || ifc.drop_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_drop ovf %b drop %0d exp 1/1", ifc.overflow, ifc.drop_cnt); end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1; ifc.in_result = 32'(i + 9);
            cyc();
        end
        n_chk++; if (ifc.level !== 3'd3) begin n_fail++; $display("FAIL mid_level level %0d exp 3", ifc.level); end
        #2 rst = 0;
        #1;
        n_chk++; if (ifc.level !== 3'd0 || ifc.out_valid !== 1'b0 || ifc.empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset level %0d valid %b empty %b exp 0/0/1", ifc.level, ifc.out_valid, ifc.empty); end
        cyc();
        idle();
        rst = 1;
        ifc.in_valid = 1; ifc.in_result = 32'h55;
        cyc();
        idle();
        n_chk++; if (ifc.out_seq !== 8'd0 || ifc.out_result !== 32'h55 || ifc.level !== 3'd1) begin n_fail++; $display("FAIL post_reset seq %0d result %h level %0d exp 0/55/1", ifc.out_seq, ifc.out_result, ifc.level); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_push_pop_full();
        test_seq_wrap();
        test_clr_vs_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ula_result_fifo.md
# ula_result_fifo

Buffers results from the ALU stage and presents them to the consumer through a valid/ready handshake. It sits directly downstream of the ALU. Each cycle in which the ALU asserts its result-valid strobe, the block captures the result, the carry-out and the operation code. Every captured entry gets an 8-bit sequence tag. Results that arrive while the buffer is full are dropped, and each drop is recorded, so the consumer can detect gaps.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- RES_W, 32, result width

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU result-valid strobe; one result per cycle in which it is high
- in_result  in  RES_W  ALU result
- in_carry  in  1  ALU carry-out
- in_op  in  5  operation selector that accompanies the result; stored verbatim
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts the head entry
- out_result  out  RES_W  head result
- out_carry  out  1  head carry-out
- out_op  out  5  head operation code
- out_seq  out  8  head sequence tag
- level  out  $clog2(DEPTH)+1  number of occupied entries
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- overflow  out  1  sticky; set when a result is dropped
- drop_cnt  out  8  number of dropped results, saturating
- clr_overflow  in  1  synchronous clear of overflow and drop_cnt

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry holds {result, carry, op, seq}.
- Read pointer and write pointer are each $clog2(DEPTH) bits and wrap naturally. Occupancy is kept in a separate counter, which drives level.
- Push condition: in_valid && (!full || pop).
- Pop condition: out_valid && out_ready.
- Push while full is accepted only if a pop happens in the same cycle. In that case level is unchanged and both pointers advance.
- Push and pop in the same cycle while not full: level is unchanged.
- Drop condition: in_valid && full && !pop. On a drop:
  - the entry is discarded and the write pointer does not move;
  - overflow is set to 1;
  - drop_cnt increments, saturating at 255.
- Sequence counter (8 bits, starts at 0):
  - advances on every in_valid cycle, whether the result is accepted or dropped;
  - wraps from 255 to 0;
  - an accepted entry stores the counter value from before the increment.
  - As a result, consecutive out_seq values differ by more than 1 exactly where results were dropped.
- out_valid equals !empty. out_result, out_carry, out_op and out_seq come from the head entry. Outputs are 0 when empty.
- While out_valid && !out_ready, all out_* signals hold stable.
- clr_overflow: on the next edge overflow goes to 0 and drop_cnt goes to 0. If a drop happens in the same cycle, the drop wins: overflow = 1 and drop_cnt = 1.
- No state machine beyond pointers and counters. Arithmetic is unsigned. level never exceeds DEPTH and never goes below 0.

## Timing
- Reset (rst = 0, asynchronous) forces the following immediately, independent of clk:
  - out_valid = 0; out_result, out_carry, out_op, out_seq = 0;
  - level = 0, empty = 1, full = 0;
  - overflow = 0, drop_cnt = 0;
  - both pointers = 0, sequence counter = 0.
- Reset release is synchronous to clk. The first push can be taken on the first rising edge with rst = 1.
- Reset during operation discards all buffered entries. No partial push is retained.
- Latency: an entry pushed at edge N is visible at the outputs with out_valid = 1 after edge N; the consumer may pop at edge N+1. Data falls through when empty; there is no extra cycle.
- Throughput: one push and one pop per cycle, sustained.
- level, full and empty update on the same edge as the push or pop that changes them.
- Signals out_ready, in_valid and clr_overflow are sampled only at rising edges.

## Test plan
- Reset check: hold rst = 0 with in_valid = 1 → all outputs at reset values, empty = 1. Release reset, push result 0x0000_00FF with in_op = 1 → next cycle out_valid = 1, out_result = 0x0000_00FF, out_op = 1, out_seq = 0.
- Fill and drain (DEPTH = 4, out_ready = 0): push results 1 through 4 → full = 1, level = 4. Raise out_ready → values 1, 2, 3, 4 appear in order with out_seq 0 to 3, then empty = 1.
- Overflow: with the buffer full and out_ready = 0, push 2 more results → overflow = 1, drop_cnt = 2. After draining, push 1 more → it appears with out_seq = 6. Assert clr_overflow → overflow = 0, drop_cnt = 0.
- Push and pop while full: with the buffer full, set in_valid = 1 and out_ready = 1 for 10 cycles → level stays 4, no drops, values come out in order, and the pointers wrap twice.
- Sequence wrap and saturation: drive in_valid for 300 cycles with out_ready = 0 →
  - drop_cnt stays at 255;
  - after draining, a new push shows out_seq = 300 mod 256 = 44.
- Clear against drop: in the same cycle as a drop, assert clr_overflow → overflow = 1, drop_cnt = 1. Assert rst mid-stream with level = 3 → level = 0 immediately and out_valid = 0.
